// File: rtl/srb_read_ctrl.sv
// srb_read_ctrl: reader for a parallel-in/serial-out input shift register
// (74HC165 class). Pulses LOAD_N, drives a divided shift clock, samples the
// synchronized serial line and publishes each frame as a parallel word with
// a one-cycle valid strobe and a change flag.
module srb_read_ctrl #(
  parameter int NBITS    = 16,
  parameter int HALF_DIV = 4,
  parameter int SYNC     = 2
) (
  input  logic             CLK_IN,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             SR_IN,
  output logic             CLK_SR,
  output logic             LOAD_N,
  output logic [NBITS-1:0] DATA_OUT,
  output logic             DATA_VALID,
  output logic             CHANGED
);

  localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NBITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_UPDATE
  } state_t;

  state_t             state_reg, state_next;
  logic [DIV_W-1:0]   div_reg, div_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [SYNC-1:0]    sync_reg;
  logic [NBITS-1:0]   shreg_reg;
  logic [NBITS-1:0]   bit_sel;
  logic [NBITS-1:0]   data_out_reg, data_out_next;
  logic               first_reg, first_next;
  logic               valid_reg, valid_next;
  logic               changed_reg, changed_next;
  logic               clk_sr_reg, clk_sr_next;
  logic               load_n_reg, load_n_next;
  logic               sample_en;
  logic               sr_sync;

  assign sr_sync    = sync_reg[SYNC-1];
  assign CLK_SR     = clk_sr_reg;
  assign LOAD_N     = load_n_reg;
  assign DATA_OUT   = data_out_reg;
  assign DATA_VALID = valid_reg;
  assign CHANGED    = changed_reg;

  // One-hot write select: bit counter value k targets shreg[NBITS-1-k],
  // so the first bit shifted out (H) ends up in the MSB.
  genvar gi;
  generate
    for (gi = 0; gi < NBITS; gi++) begin : g_bit_sel
      assign bit_sel[gi] = (cnt_reg == CNT_W'(NBITS - 1 - gi));
    end
  endgenerate

  // Synchronizer chain for the asynchronous serial input.
  always_ff @(posedge CLK_IN) begin
    if (!RST_N) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC-2:0], SR_IN};
    end
  end

  // Assembly register: captures one synchronized bit at the end of each low phase.
  always_ff @(posedge CLK_IN) begin
    if (!RST_N) begin
      shreg_reg <= '0;
    end else if (sample_en) begin
      shreg_reg <= (shreg_reg & ~bit_sel) | ({NBITS{sr_sync}} & bit_sel);
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK_IN) begin
    if (!RST_N) begin
      state_reg    <= S_IDLE;
      div_reg      <= '0;
      cnt_reg      <= '0;
      first_reg    <= 1'b1;
      data_out_reg <= '0;
      valid_reg    <= 1'b0;
      changed_reg  <= 1'b0;
      clk_sr_reg   <= 1'b0;
      load_n_reg   <= 1'b1;
    end else begin
      state_reg    <= state_next;
      div_reg      <= div_next;
      cnt_reg      <= cnt_next;
      first_reg    <= first_next;
      data_out_reg <= data_out_next;
      valid_reg    <= valid_next;
      changed_reg  <= changed_next;
      clk_sr_reg   <= clk_sr_next;
      load_n_reg   <= load_n_next;
    end
  end

  // Next-state logic; pin levels follow the state being entered so they line up with it.
  always_comb begin
    state_next    = state_reg;
    div_next      = div_reg;
    cnt_next      = cnt_reg;
    first_next    = first_reg;
    data_out_next = data_out_reg;
    valid_next    = 1'b0;
    changed_next  = 1'b0;
    sample_en     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        div_next = '0;
        if (EN) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (div_reg == DIV_LAST) begin
          div_next   = '0;
          state_next = S_HOLD;
        end else begin
          div_next = div_reg + DIV_W'(1);
        end
      end
      S_HOLD: begin
        if (div_reg == DIV_LAST) begin
          div_next   = '0;
          state_next = S_SHIFT_LO;
        end else begin
          div_next = div_reg + DIV_W'(1);
        end
      end
      S_SHIFT_LO: begin
        if (div_reg == DIV_LAST) begin
          div_next  = '0;
          sample_en = 1'b1;
          // No trailing shift edge after the final sample.
          if (cnt_reg == LAST_BIT) begin
            state_next = S_UPDATE;
          end else begin
            state_next = S_SHIFT_HI;
          end
        end else begin
          div_next = div_reg + DIV_W'(1);
        end
      end
      S_SHIFT_HI: begin
        if (div_reg == DIV_LAST) begin
          div_next   = '0;
          cnt_next   = cnt_reg + CNT_W'(1);
          state_next = S_SHIFT_LO;
        end else begin
          div_next = div_reg + DIV_W'(1);
        end
      end
      S_UPDATE: begin
        div_next      = '0;
        cnt_next      = '0;
        data_out_next = shreg_reg;
        valid_next    = 1'b1;
        // The first frame after reset always reports a change, even if it is all zeros.
        changed_next  = (shreg_reg != data_out_reg) || first_reg;
        first_next    = 1'b0;
        state_next    = EN ? S_LOAD : S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        div_next   = '0;
        cnt_next   = '0;
      end
    endcase

    clk_sr_next = (state_next == S_SHIFT_HI);
    load_n_next = (state_next != S_LOAD);
  end

endmodule

// File: tb/tb_srb_read_ctrl.sv
// Directed testbench for srb_read_ctrl with a behavioural 16-bit PISO register.
module tb_srb_read_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        en;
  logic        sr_in;
  logic        clk_sr;
  logic        load_n;
  logic [15:0] data_out;
  logic        data_valid;
  logic        changed;

  logic [15:0] par_in = 16'h0000;
  logic [15:0] piso   = 16'h0000;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int sr_rise = 0;
  int load_low = 0;
  int valid_total = 0;
  logic clk_sr_prev = 1'b0;

  srb_read_ctrl #(.NBITS(16), .HALF_DIV(4), .SYNC(2)) dut (
    .CLK_IN    (clk_in),
    .RST_N     (rst_n),
    .EN        (en),
    .SR_IN     (sr_in),
    .CLK_SR    (clk_sr),
    .LOAD_N    (load_n),
    .DATA_OUT  (data_out),
    .DATA_VALID(data_valid),
    .CHANGED   (changed)
  );

  always #5 clk_in = ~clk_in;

  // 74HC165 model: parallel load on LOAD_N low, shift towards H on CLK_SR rise.
  always @(posedge clk_sr or negedge load_n) begin
    if (!load_n) piso <= par_in;
    else         piso <= {piso[14:0], 1'b0};
  end
  assign sr_in = piso[15];

  // Running counters of pin activity, sampled on each system clock edge.
  always @(posedge clk_in) begin
    cyc         <= cyc + 1;
    clk_sr_prev <= clk_sr;
    if (clk_sr && !clk_sr_prev) sr_rise <= sr_rise + 1;
    if (!load_n) load_low <= load_low + 1;
    if (data_valid) valid_total <= valid_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int max);
    bit got = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (!got) begin
        @(negedge clk_in);
        if (data_valid) got = 1'b1;
      end
    end
    check({tag, "_valid_seen"}, 32'(got), 32'd1);
  endtask

  task automatic wait_load(input string tag, input int max);
    bit got = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (!got) begin
        @(negedge clk_in);
        if (!load_n) got = 1'b1;
      end
    end
    check({tag, "_load_seen"}, 32'(got), 32'd1);
  endtask

  task automatic wait_rises(input string tag, input int n, input int max);
    int   seen = 0;
    logic prev = clk_sr;
    for (int i = 0; i < max; i++) begin
      if (seen < n) begin
        @(negedge clk_in);
        if (clk_sr && !prev) seen++;
        prev = clk_sr;
      end
    end
    check({tag, "_rises_seen"}, 32'(seen), 32'(n));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_in);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c_load, c_prev, s_rise, s_low, s_valid, k;

    // Reset hold
    rst_n = 1'b0;
    en    = 1'b0;
    step(5);
    check("rst_clk_sr", 32'(clk_sr), 32'd0);
    check("rst_load_n", 32'(load_n), 32'd1);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_changed", 32'(changed), 32'd0);

    // Release with EN low: nothing happens for 500 cycles
    rst_n = 1'b1;
    step(1);
    s_rise = sr_rise; s_low = load_low; s_valid = valid_total;
    step(500);
    check("idle_valid_cnt", 32'(valid_total - s_valid), 32'd0);
    check("idle_rise_cnt", 32'(sr_rise - s_rise), 32'd0);
    check("idle_load_cnt", 32'(load_low - s_low), 32'd0);
    check("idle_load_n", 32'(load_n), 32'd1);
    check("idle_data_out", 32'(data_out), 32'h0);
    $display("[TB] idle 500 cycles: valid=%0d rises=%0d", valid_total - s_valid, sr_rise - s_rise);

    // Frame 1: A5C3, first frame
    par_in = 16'hA5C3;
    s_rise = sr_rise; s_low = load_low;
    en = 1'b1;
    wait_load("f1", 5);
    c_load = cyc;
    wait_valid("f1", 200);
    check("f1_data", 32'(data_out), 32'hA5C3);
    check("f1_changed", 32'(changed), 32'd1);
    check("f1_latency", 32'(cyc - c_load), 32'd133);
    check("f1_load_cycles", 32'(load_low - s_low), 32'd4);
    check("f1_sr_rises", 32'(sr_rise - s_rise), 32'd15);
    $display("[TB] frame1 data=%04h changed=%0b latency=%0d", data_out, changed, cyc - c_load);
    c_prev = cyc;

    // Frame 2: same word
    wait_valid("f2", 200);
    check("f2_data", 32'(data_out), 32'hA5C3);
    check("f2_changed", 32'(changed), 32'd0);
    check("f2_period", 32'(cyc - c_prev), 32'd133);
    $display("[TB] frame2 data=%04h changed=%0b period=%0d", data_out, changed, cyc - c_prev);
    c_prev = cyc;
    step(1);
    check("f2_valid_pulse", 32'(data_valid), 32'd0);
    check("f2_changed_pulse", 32'(changed), 32'd0);
    // Frame 3 already loaded A5C3; the new word applies from frame 4
    par_in = 16'hA5C2;

    wait_valid("f3", 200);
    check("f3_data", 32'(data_out), 32'hA5C3);
    check("f3_changed", 32'(changed), 32'd0);
    check("f3_period", 32'(cyc - c_prev), 32'd133);
    $display("[TB] frame3 data=%04h changed=%0b", data_out, changed);

    wait_valid("f4", 200);
    check("f4_data", 32'(data_out), 32'hA5C2);
    check("f4_changed", 32'(changed), 32'd1);
    $display("[TB] frame4 data=%04h changed=%0b", data_out, changed);

    // Frame 5: drop EN during the 8th high phase
    wait_rises("f5", 8, 200);
    check("f5_in_shift_hi", 32'(clk_sr), 32'd1);
    en = 1'b0;
    wait_valid("f5", 200);
    check("f5_data", 32'(data_out), 32'hA5C2);
    check("f5_changed", 32'(changed), 32'd0);
    check("f5_idle_load_n", 32'(load_n), 32'd1);
    check("f5_idle_clk_sr", 32'(clk_sr), 32'd0);
    $display("[TB] frame5 data=%04h changed=%0b then idle", data_out, changed);
    step(1);
    s_rise = sr_rise; s_low = load_low; s_valid = valid_total;
    step(20);
    check("idle2_valid_cnt", 32'(valid_total - s_valid), 32'd0);
    check("idle2_rise_cnt", 32'(sr_rise - s_rise), 32'd0);
    check("idle2_load_cnt", 32'(load_low - s_low), 32'd0);
    check("idle2_data_hold", 32'(data_out), 32'hA5C2);
    en = 1'b1;
    step(1);
    check("restart_load_n", 32'(load_n), 32'd0);
    $display("[TB] restart: load_n=%0b one cycle after EN", load_n);

    // Frame 6: reset in the low phase of bit 5
    wait_rises("f6", 5, 200);
    k = 0;
    while (clk_sr && k < 20) begin
      step(1);
      k++;
    end
    check("f6_in_shift_lo", 32'(clk_sr), 32'd0);
    step(2);
    s_valid = valid_total;
    par_in = 16'h0000;
    rst_n = 1'b0;
    step(3);
    check("mid_rst_clk_sr", 32'(clk_sr), 32'd0);
    check("mid_rst_load_n", 32'(load_n), 32'd1);
    check("mid_rst_data_out", 32'(data_out), 32'h0);
    check("mid_rst_valid", 32'(data_valid), 32'd0);
    rst_n = 1'b1;
    wait_load("f7", 5);
    c_load = cyc;
    check("abort_no_valid", 32'(valid_total - s_valid), 32'd0);
    $display("[TB] reset mid-frame: valid pulses during abort=%0d", valid_total - s_valid);

    // Frame 7: all zeros after reset still reports a change
    wait_valid("f7", 200);
    check("f7_data", 32'(data_out), 32'h0);
    check("f7_changed", 32'(changed), 32'd1);
    check("f7_latency", 32'(cyc - c_load), 32'd133);
    $display("[TB] frame7 data=%04h changed=%0b", data_out, changed);
    step(1);
    par_in = 16'h5A5A;

    wait_valid("f8", 200);
    check("f8_data", 32'(data_out), 32'h0);
    check("f8_changed", 32'(changed), 32'd0);
    $display("[TB] frame8 data=%04h changed=%0b", data_out, changed);

    wait_valid("f9", 200);
    check("f9_data", 32'(data_out), 32'h5A5A);
    check("f9_changed", 32'(changed), 32'd1);
    $display("[TB] frame9 data=%04h changed=%0b", data_out, changed);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
